sync_fifo_param: RTL

Parametrised synchronous FIFO for UART TX/RX buffering and general byte/word queuing between the UART, command decoder and watch/stopwatch control paths. It generalises the fixed 8-bit × 16-entry FIFO with configurable width and depth, an occupancy counter, programmable almost-full/almost-empty flags, and simultaneous read/write when full. It also provides optional sticky overflow/underflow error flags. Read data is show-ahead: `rdata` always presents the head entry while `empty` is low.

---
 rtl/fifo_pkg.sv | 14 +
 rtl/fifo_mem.sv | 25 ++
 rtl/sync_fifo_param.sv | 132 +++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised synchronous FIFO.
package fifo_pkg;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 4;

    localparam logic [1:0] OP_IDLE = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_PUSH = 2'b10;
    localparam logic [1:0] OP_BOTH = 2'b11;

    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction
endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH register file: synchronous write, combinational read.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    localparam int DEPTH = fifo_depth(ADDR_WIDTH);

    // Contents are intentionally not reset.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised show-ahead synchronous FIFO with occupancy count and almost flags.
// Optional sticky overflow/underflow flags are enabled by defining FIFO_ERR_FLAGS_EN.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int AFULL_TH   = 12,
    parameter int AEMPTY_TH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  full,
    output logic                  almost_full,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  err_clr
);
    localparam int DEPTH = fifo_depth(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0]   DEPTH_C  = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0]   AFULL_C  = AFULL_TH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0]   AEMPTY_C = AEMPTY_TH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  full_q, full_d, empty_q, empty_d;
    logic                  push, pop;

    // A write while full is accepted only when a read frees the slot in the same cycle.
    assign push = wr & (~full_q | rd);
    assign pop  = rd & ~empty_q;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        full_d  = full_q;
        empty_d = empty_q;
        case ({push, pop})
            OP_PUSH: begin
                wptr_d  = wptr_q + PTR_ONE;
                count_d = count_q + CNT_ONE;
                empty_d = 1'b0;
                full_d  = (count_d == DEPTH_C);
            end
            OP_POP: begin
                rptr_d  = rptr_q + PTR_ONE;
                count_d = count_q - CNT_ONE;
                full_d  = 1'b0;
                empty_d = (count_d == '0);
            end
            OP_BOTH: begin
                wptr_d = wptr_q + PTR_ONE;
                rptr_d = rptr_q + PTR_ONE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    fifo_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mem (
        .clk  (clk),
        .we   (push),
        .waddr(wptr_q),
        .wdata(wdata),
        .raddr(rptr_q),
        .rdata(rdata)
    );

    assign full         = full_q;
    assign empty        = empty_q;
    assign count        = count_q;
    assign almost_full  = (count_q >= AFULL_C);
    assign almost_empty = (count_q <= AEMPTY_C);

`ifdef FIFO_ERR_FLAGS_EN
    logic overflow_q, overflow_d, underflow_q, underflow_d;

    // Error events are applied after the clear so they win when coincident.
    always_comb begin
        overflow_d  = overflow_q & ~err_clr;
        underflow_d = underflow_q & ~err_clr;
        if (wr & full_q & ~rd)   overflow_d  = 1'b1;
        if (rd & empty_q & ~wr)  underflow_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif
endmodule
